// File: rtl/carry_save_accumulate_ctrl_if.sv
// Operand stream in, resolved result stream out, for the carry-save accumulator.
// master: operand source / result consumer; slave: the accumulator.
interface carry_save_accumulate_ctrl_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;

  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_ovf;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf,
    input  out_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf,
    output out_count
  );

endinterface

// File: rtl/carry_save_accumulate_ctrl.sv
// Multi-operand unsigned accumulator: folds one operand per cycle into a redundant
// (sum, carry) pair, then resolves it to binary K bits per cycle and presents the result.
module carry_save_accumulate_ctrl #(
  parameter int unsigned N  = 32,
  parameter int unsigned K  = 8,
  parameter int unsigned CW = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        abort,
  carry_save_accumulate_ctrl_if.slave bus,
  output logic                        busy
);

  localparam int unsigned NC  = N / K;
  localparam int unsigned CiW = (NC > 1) ? $clog2(NC) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAccum   = 2'd1;
  localparam logic [1:0] StResolve = 2'd2;
  localparam logic [1:0] StOutput  = 2'd3;

  if ((N % K) != 0) begin : g_bad_chunking
    $error("carry_save_accumulate_ctrl: N must be a multiple of K");
  end

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   s_q, s_d;
  logic [N-1:0]   c_q, c_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CiW-1:0] ci_q, ci_d;
  logic           cy_q, cy_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           out_ovf_q, out_ovf_d;
  logic [CW-1:0]  out_count_q, out_count_d;

  logic           accept;
  logic [N-1:0]   maj;
  logic [K-1:0]   s_chunk;
  logic [K-1:0]   c_chunk;
  logic [K:0]     chunk_sum;
  logic           last_chunk;
  logic [CW-1:0]  cnt_inc;

  assign bus.in_ready = rst_n & ~abort & ((state_q == StIdle) | (state_q == StAccum));
  assign accept       = bus.in_valid & bus.in_ready;

  // Full-adder row: S^C^d keeps the sum bits, the majority carries move up one place.
  assign maj     = (s_q & c_q) | (s_q & bus.in_data) | (c_q & bus.in_data);
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    s_chunk = '0;
    c_chunk = '0;
    for (int unsigned g = 0; g < NC; g++) begin
      if (ci_q == CiW'(g)) begin
        s_chunk = s_q[g*K +: K];
        c_chunk = c_q[g*K +: K];
      end
    end
  end

  assign chunk_sum  = {1'b0, s_chunk} + {1'b0, c_chunk} + {{K{1'b0}}, cy_q};
  assign last_chunk = (ci_q == CiW'(NC - 1));

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    ci_d        = ci_q;
    cy_d        = cy_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;

    if (abort) begin
      state_d = StIdle;
      ci_d    = '0;
      cy_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            s_d     = bus.in_data;
            c_d     = '0;
            ovf_d   = 1'b0;
            cnt_d   = CW'(1);
            ci_d    = '0;
            cy_d    = 1'b0;
            state_d = bus.in_last ? StResolve : StAccum;
          end
        end

        StAccum: begin
          if (accept) begin
            s_d   = s_q ^ c_q ^ bus.in_data;
            c_d   = {maj[N-2:0], 1'b0};
            // The dropped top majority bit has weight 2^N.
            ovf_d = ovf_q | maj[N-1];
            cnt_d = cnt_inc;
            if (bus.in_last) begin
              state_d = StResolve;
              ci_d    = '0;
              cy_d    = 1'b0;
            end
          end
        end

        StResolve: begin
          // Resolved chunks overwrite S in place; later chunks are still unread.
          for (int unsigned g = 0; g < NC; g++) begin
            if (ci_q == CiW'(g)) begin
              s_d[g*K +: K] = chunk_sum[K-1:0];
            end
          end
          cy_d = chunk_sum[K];
          ci_d = ci_q + CiW'(1);
          if (last_chunk) begin
            ovf_d       = ovf_q | chunk_sum[K];
            out_data_d  = s_d;
            out_ovf_d   = ovf_q | chunk_sum[K];
            out_count_d = cnt_q;
            ci_d        = '0;
            cy_d        = 1'b0;
            state_d     = StOutput;
          end
        end

        StOutput: begin
          if (bus.out_ready) begin
            state_d = StIdle;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      s_q         <= '0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      ci_q        <= '0;
      cy_q        <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      ci_q        <= ci_d;
      cy_q        <= cy_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.out_valid = (state_q == StOutput);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_count = out_count_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_carry_save_accumulate_ctrl.sv
// Bench for carry_save_accumulate_ctrl: two instances (CW=8 and CW=2) share one stimulus
// stream; a transaction-level model is compared against both on every cycle.
module tb_carry_save_accumulate_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned K  = 4;
  localparam int unsigned NK = N / K;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic abort = 1'b0;
  logic busy, busy2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;
  int lat;

  carry_save_accumulate_ctrl_if #(.N(N), .CW(8)) bus  ();
  carry_save_accumulate_ctrl_if #(.N(N), .CW(2)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  carry_save_accumulate_ctrl #(.N(N), .K(K), .CW(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (abort),
    .bus   (bus),
    .busy  (busy)
  );

  carry_save_accumulate_ctrl #(.N(N), .K(K), .CW(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (abort),
    .bus   (bus2),
    .busy  (busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: group sum as a plain integer, output timing as a countdown.
  logic           m_coll;
  longint         m_sum;
  int             m_cnt;
  int             m_wait;
  logic           m_outv;
  logic [N-1:0]   m_data;
  logic           m_ovf;
  int             m_ocnt;
  logic           m_rdy;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task model_reset();
    m_coll = 1'b0;
    m_sum  = 0;
    m_cnt  = 0;
    m_wait = 0;
    m_outv = 1'b0;
    m_data = '0;
    m_ovf  = 1'b0;
    m_ocnt = 0;
  endtask

  task model_compare();
    m_rdy = rst_n && !abort && (m_wait == 0) && !m_outv;
    chk("in_ready",   bus.in_ready,   m_rdy);
    chk("out_valid",  bus.out_valid,  m_outv);
    chk("out_data",   bus.out_data,   m_data);
    chk("out_ovf",    bus.out_ovf,    m_ovf);
    chk("out_count",  bus.out_count,  sat(m_ocnt, 255));
    chk("busy",       busy,           m_coll || (m_wait > 0) || m_outv);
    chk("in_ready2",  bus2.in_ready,  m_rdy);
    chk("out_valid2", bus2.out_valid, m_outv);
    chk("out_data2",  bus2.out_data,  m_data);
    chk("out_ovf2",   bus2.out_ovf,   m_ovf);
    chk("out_count2", bus2.out_count, sat(m_ocnt, 3));
    chk("busy2",      busy2,          m_coll || (m_wait > 0) || m_outv);
  endtask

  task model_step();
    if (abort) begin
      m_coll = 1'b0;
      m_wait = 0;
      m_outv = 1'b0;
    end else if (m_outv) begin
      if (bus.out_ready) m_outv = 1'b0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_outv = 1'b1;
        m_data = m_sum[N-1:0];
        m_ovf  = (m_sum >= (64'd1 << N));
        m_ocnt = m_cnt;
      end
    end else if (m_rdy && bus.in_valid) begin
      if (!m_coll) begin
        m_sum = longint'(bus.in_data);
        m_cnt = 1;
      end else begin
        m_sum = m_sum + longint'(bus.in_data);
        m_cnt++;
      end
      if (bus.in_last) begin
        m_coll = 1'b0;
        m_wait = NK;
      end else begin
        m_coll = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    model_compare();
    if (rst_n) model_step();
  end

  // Called just after a rising edge; returns just after the rising edge that accepts.
  task automatic send(input logic [N-1:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    chk("send_accept", bus.in_ready, 1'b1);
    last_acc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Returns at the falling edge where out_valid is first seen.
  task automatic wait_out(output int l);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 50);
    chk("out_valid_seen", bus.out_valid, 1'b1);
    l = cyc - last_acc;
  endtask

  task automatic check_result(input string name, input logic [N-1:0] d, input logic o,
                              input int c1, input int c2);
    chk({name, "_data"},   bus.out_data,   d);
    chk({name, "_ovf"},    bus.out_ovf,    o);
    chk({name, "_count"},  bus.out_count,  c1);
    chk({name, "_count2"}, bus2.out_count, c2);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_low", bus.in_ready, 1'b0);
    chk("rst_out_valid",    bus.out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1'b1);
    chk("rel_busy",     busy,         1'b0);
    realign();

    // 1: 0x10+0x20+0x30
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    wait_out(lat);
    chk("t1_latency", lat, 3);
    check_result("t1", 8'h60, 1'b0, 3, 3);
    realign();

    // 2: 0xFF+0x01 wraps
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    wait_out(lat);
    check_result("t2", 8'h00, 1'b1, 2, 2);
    realign();

    // 3: single operand
    send(8'hA5, 1'b1);
    wait_out(lat);
    check_result("t3", 8'hA5, 1'b0, 1, 1);
    realign();

    // 4: 3 x 0x80 with stalled consumer
    bus.out_ready = 1'b0;
    send(8'h80, 1'b0);
    send(8'h80, 1'b0);
    send(8'h80, 1'b1);
    wait_out(lat);
    check_result("t4", 8'h80, 1'b1, 3, 3);
    repeat (4) begin
      @(negedge clk);
      chk("t4_hold_valid", bus.out_valid, 1'b1);
      chk("t4_hold_data",  bus.out_data,  8'h80);
      chk("t4_hold_rdy",   bus.in_ready,  1'b0);
    end
    realign();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_rdy", bus.in_ready, 1'b0);
    @(negedge clk);
    chk("t4_post_rdy",   bus.in_ready,  1'b1);
    chk("t4_post_valid", bus.out_valid, 1'b0);
    realign();

    // 5: abort in first resolve cycle, then abort racing an operand
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    chk("t5_busy_during", busy, 1'b1);
    realign();
    abort = 1'b0;
    @(negedge clk);
    chk("t5_busy_after",  busy,          1'b0);
    chk("t5_no_valid",    bus.out_valid, 1'b0);
    realign();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_last  = 1'b1;
    abort        = 1'b1;
    @(negedge clk);
    chk("t5_abort_rdy", bus.in_ready, 1'b0);
    realign();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    abort        = 1'b0;
    @(negedge clk);
    chk("t5_not_taken", busy, 1'b0);
    realign();
    send(8'h01, 1'b1);
    wait_out(lat);
    check_result("t5", 8'h01, 1'b0, 1, 1);
    realign();

    // abort beats a handshake in OUTPUT; data stays
    bus.out_ready = 1'b0;
    send(8'h05, 1'b1);
    wait_out(lat);
    realign();
    abort         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ab_out_valid", bus.out_valid, 1'b1);
    realign();
    abort = 1'b0;
    @(negedge clk);
    chk("ab_dropped", bus.out_valid, 1'b0);
    chk("ab_held",    bus.out_data,  8'h05);
    realign();

    // 6: five 0x01, count saturates at 3 in the CW=2 instance
    for (int i = 0; i < 5; i++) send(8'h01, (i == 4));
    wait_out(lat);
    check_result("t6", 8'h05, 1'b0, 5, 3);
    realign();

    // async reset mid-group discards it
    send(8'h33, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ar_busy", busy,         1'b0);
    chk("ar_rdy",  bus.in_ready, 1'b0);
    realign();
    rst_n = 1'b1;
    send(8'h44, 1'b1);
    wait_out(lat);
    check_result("ar", 8'h44, 1'b0, 1, 1);
    realign();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
